sum_window_accum: RTL and testbench

- Downstream consumer of the 8-bit operand-sum stream (ui_in + uio_in) produced by the tile top.
- Accumulates WINDOW consecutive accepted samples into a 16-bit total.
- Streams each total out as two bytes, low byte then high byte, over a valid/ready handshake.
- Accumulation of the next window continues while the previous total is being sent (one-deep hold buffer).

---
 rtl/sum_accum_pkg.sv | 30 +++
 rtl/sum_byte_tx.sv | 72 +++++++
 rtl/sum_window_accum.sv | 98 +++++++++
 tb/tb_sum_window_accum.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sum_accum_pkg.sv
// Shared types and helpers for the windowed sum accumulator.
`timescale 1ns/1ps
package sum_accum_pkg;

    localparam int ACC_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } tx_state_t;

    // Adds a byte to a 16-bit total. Bit ACC_W of the result is the carry
    // (the true sum exceeded 0xFFFF). The low ACC_W bits are either the
    // wrapped sum or, when sat is set and there was a carry, 0xFFFF.
    function automatic logic [ACC_W:0] sat_add16(
        input logic [ACC_W-1:0]  a,
        input logic [BYTE_W-1:0] b,
        input logic              sat
    );
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - BYTE_W){1'b0}}, b};
        if (sat && s[ACC_W]) begin
            s = {1'b1, {ACC_W{1'b1}}};
        end
        return s;
    endfunction

endpackage

// File: rtl/sum_byte_tx.sv
// Holds one 16-bit total and sends it as two bytes (low, then high) over a
// valid/ready handshake. busy is high whenever the hold register is in use.
`timescale 1ns/1ps
module sum_byte_tx
    import sum_accum_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [ACC_W-1:0] load_value,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    tx_state_t        state_q, state_d;
    logic [ACC_W-1:0] hold_q;

    // State and hold register; load only arrives while idle, so hold is
    // never overwritten while a byte of it is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                hold_q <= load_value;
            end
        end
    end

    // Next state and byte outputs; outputs depend only on state and hold so
    // they stay stable while the sink stalls.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                out_valid = 1'b1;
                out_data  = hold_q[BYTE_W-1:0];
                if (out_ready && ena) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_data  = hold_q[ACC_W-1:BYTE_W];
                out_last  = 1'b1;
                if (out_ready && ena) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/sum_window_accum.sv
// Accumulates WINDOW accepted samples into a 16-bit total and hands each
// total to sum_byte_tx for byte-serial output. Build option SUM_ACC_SAT_EN
// makes the accumulator saturate at 0xFFFF instead of wrapping.
// WINDOW must lie in 2..1024.
`timescale 1ns/1ps
module sum_window_accum
    import sum_accum_pkg::*;
#(
    parameter int WINDOW = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       ovf
);

    localparam int               CNT_W    = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

`ifdef SUM_ACC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             live_q;
    logic [ACC_W:0]   sum;
    logic             window_last;
    logic             accept;
    logic             tx_busy;

    assign sum         = sat_add16(acc_q, in_data, SAT_EN);
    assign window_last = (cnt_q == LAST_CNT);
    // The closing sample waits until the previous total has left the hold
    // register; every other sample flows freely during a send.
    assign in_ready    = live_q & ena & ~(tx_busy & window_last);
    assign accept      = in_valid & in_ready;
    assign ovf         = ovf_q;

    // Accumulator, sample counter and sticky overflow next-state.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            if (window_last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_q + 1'b1;
            end
            if (sum[ACC_W]) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers; live_q keeps in_ready low until the first edge
    // after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            live_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            live_q <= 1'b1;
        end
    end

    sum_byte_tx u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .load       (accept & window_last),
        .load_value (sum[ACC_W-1:0]),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (tx_busy)
    );

endmodule

// File: tb/tb_sum_window_accum.sv
// Scoreboard bench: instance A (WINDOW=4) for functional cases, instance B
// (WINDOW=300) for the overflow case.
`timescale 1ns/1ps
module tb_sum_window_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena;
    logic [7:0] in_data_a, out_data_a, in_data_b, out_data_b;
    logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, ovf_a;
    logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, ovf_b;

    sum_window_accum #(.WINDOW(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_last(out_last_a), .ovf(ovf_a)
    );

    sum_window_accum #(.WINDOW(300)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_last(out_last_b), .ovf(ovf_b)
    );

    int checks   = 0;
    int failures = 0;
    logic [8:0] q_a[$];   // {last, data}
    logic [8:0] q_b[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pops and compares one expected byte per output handshake.
    task automatic monitor_loop();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && ena && out_valid_a && out_ready_a) begin
                $display("a byte data=0x%02h last=%0b", out_data_a, out_last_a);
                if (q_a.size() == 0) begin
                    check("a_unexpected_byte", int'({out_last_a, out_data_a}), -1);
                end else begin
                    e = q_a.pop_front();
                    check("a_byte", int'({out_last_a, out_data_a}), int'(e));
                end
            end
            if (rst_n && ena && out_valid_b && out_ready_b) begin
                $display("b byte data=0x%02h last=%0b", out_data_b, out_last_b);
                if (q_b.size() == 0) begin
                    check("b_unexpected_byte", int'({out_last_b, out_data_b}), -1);
                end else begin
                    e = q_b.pop_front();
                    check("b_byte", int'({out_last_b, out_data_b}), int'(e));
                end
            end
        end
    endtask

    // Presents one sample and returns #1 after the edge that accepts it.
    task automatic send_sample(input bit sel, input logic [7:0] d);
        int n;
        n = 0;
        if (sel) begin in_valid_b = 1'b1; in_data_b = d; end
        else     begin in_valid_a = 1'b1; in_data_a = d; end
        forever begin
            @(negedge clk);
            if (sel ? in_ready_b : in_ready_a) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", q_a.size() + q_b.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1;
        in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_out_data",  int'(out_data_a), 0);
        check("rst_out_last",  int'(out_last_a), 0);
        check("rst_ovf",       int'(ovf_a), 0);
        check("rst_in_ready",  int'(in_ready_a), 0);
        rst_n = 1'b1;
        #2;
        check("in_ready_before_edge", int'(in_ready_a), 0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", int'(in_ready_a), 1);

        // Basic window: 0x10+0x20+0x30+0x40 = 0x00A0
        q_a.push_back({1'b0, 8'hA0}); q_a.push_back({1'b1, 8'h00});
        send_sample(0, 8'h10); send_sample(0, 8'h20); send_sample(0, 8'h30);
        check("valid_before_close", int'(out_valid_a), 0);
        send_sample(0, 8'h40);
        check("valid_after_close", int'(out_valid_a), 1);
        in_valid_a = 1'b0;
        drain();
        check("basic_ovf", int'(ovf_a), 0);

        // Output stall: 0xFF x4 = 0x03FC held; next window 1+2+3+4 = 0x000A
        out_ready_a = 1'b0;
        q_a.push_back({1'b0, 8'hFC}); q_a.push_back({1'b1, 8'h03});
        for (int i = 0; i < 4; i++) send_sample(0, 8'hFF);
        send_sample(0, 8'h01); send_sample(0, 8'h02); send_sample(0, 8'h03);
        check("stall_data", int'(out_data_a), 'hFC);
        in_valid_a = 1'b1; in_data_a = 8'h04;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready_a), 0);
            check("stall_hold_data", int'(out_data_a), 'hFC);
        end
        @(posedge clk);
        #1;
        q_a.push_back({1'b0, 8'h0A}); q_a.push_back({1'b1, 8'h00});
        out_ready_a = 1'b1;
        send_sample(0, 8'h04);
        check("stall_new_total_lo", int'(out_data_a), 'h0A);
        in_valid_a = 1'b0;
        drain();

        // Back-to-back windows: 1+2+3+4 = 0x0A, 5+6+7+8 = 0x1A
        q_a.push_back({1'b0, 8'h0A}); q_a.push_back({1'b1, 8'h00});
        q_a.push_back({1'b0, 8'h1A}); q_a.push_back({1'b1, 8'h00});
        for (int i = 1; i <= 8; i++) send_sample(0, 8'(i));
        in_valid_a = 1'b0;
        drain();

        // ena gaps mid-window and mid-send: 0x11+0x22+0x33+0x44 = 0x00AA
        q_a.push_back({1'b0, 8'hAA}); q_a.push_back({1'b1, 8'h00});
        send_sample(0, 8'h11); send_sample(0, 8'h22); send_sample(0, 8'h33);
        in_valid_a = 1'b1; in_data_a = 8'h99;
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ena_in_ready", int'(in_ready_a), 0);
            check("ena_idle_valid", int'(out_valid_a), 0);
        end
        @(posedge clk);
        #1;
        ena = 1'b1; out_ready_a = 1'b0;
        send_sample(0, 8'h44);
        in_valid_a = 1'b0;
        ena = 1'b0; out_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ena_send_valid", int'(out_valid_a), 1);
            check("ena_send_data", int'(out_data_a), 'hAA);
            check("ena_send_last", int'(out_last_a), 0);
        end
        @(posedge clk);
        #1;
        ena = 1'b1;
        drain();

        // Overflow on B: 300 x 0xFF = 76500
`ifdef SUM_ACC_SAT_EN
        q_b.push_back({1'b0, 8'hFF}); q_b.push_back({1'b1, 8'hFF});
`else
        q_b.push_back({1'b0, 8'hD4}); q_b.push_back({1'b1, 8'h2A});
`endif
        for (int i = 0; i < 257; i++) send_sample(1, 8'hFF);
        check("ovf_at_ffff", int'(ovf_b), 0);     // 257*255 = 0xFFFF exactly
        send_sample(1, 8'hFF);
        check("ovf_past_ffff", int'(ovf_b), 1);
        for (int i = 0; i < 42; i++) send_sample(1, 8'hFF);
        in_valid_b = 1'b0;
        drain();
        check("ovf_sticky", int'(ovf_b), 1);
        check("ovf_a_clear", int'(ovf_a), 0);

        // Async reset while SEND_HI is stalled
        out_ready_a = 1'b0;
        q_a.push_back({1'b0, 8'h04});
        for (int i = 0; i < 4; i++) send_sample(0, 8'h01);
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a = 1'b0;
        check("mid_send_last", int'(out_last_a), 1);
        check("mid_send_valid", int'(out_valid_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid_a), 0);
        check("async_rst_last", int'(out_last_a), 0);
        check("async_rst_ovf_b", int'(ovf_b), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a = 1'b1;
        q_a.push_back({1'b0, 8'h14}); q_a.push_back({1'b1, 8'h00});
        for (int i = 0; i < 4; i++) send_sample(0, 8'h05);
        in_valid_a = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
